// File: rtl/pipeline_biss_pkg.sv
// Shared constants for the +10/+100/+1000 token encoding (encoder and decoder stages).
// Latency: n/a (package only).
// Backpressure: n/a.
package pipeline_biss_pkg;

    // Offsets added by the encoder; the decoder removes them in reverse order.
    localparam int unsigned OFF1          = 1000;
    localparam int unsigned OFF2          = 100;
    localparam int unsigned OFF3          = 10;
    // Smallest encoded value that decodes without wrapping below zero.
    localparam int unsigned UNDERFLOW_MIN = OFF1 + OFF2 + OFF3;

endpackage

// File: rtl/pipeline_biss_rev_stage.sv
// One decode stage: registers (upstream data - OFFSET) with a valid bit.
// Latency: 1 cycle per stage; data held while downstream stalls.
// Backpressure: ready when empty or when downstream is ready (combinational pass-through).
// Ports: clk/rst; up_vld_i/up_dat_i/up_rdy_o upstream handshake;
//        dn_vld_o/dn_dat_o/dn_rdy_i downstream handshake.
module pipeline_biss_rev_stage #(
    parameter int          WIDTH  = 16,
    parameter int unsigned OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_dat_i,
    output logic             up_rdy_o,
    output logic             dn_vld_o,
    output logic [WIDTH-1:0] dn_dat_o,
    input  logic             dn_rdy_i
);

    localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    assign up_rdy_o = !vld_q || dn_rdy_i;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (up_rdy_o) begin
            vld_d = up_vld_i;
            // Data only changes on a load, so a drained stage keeps its old value.
            if (up_vld_i) begin
                dat_d = up_dat_i - OFF_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign dn_vld_o = vld_q;
    assign dn_dat_o = dat_q;

endmodule

// File: rtl/pipeline_biss_rev.sv
// Three-stage decoder removing 1000, 100, 10; bubbles and underflows are accepted and dropped.
// Latency: 3 cycles input transfer to out_valid; 1 token/cycle throughput.
// Backpressure: valid/ready chain; in_ready low only when all stages full and out_ready low.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready; out_data/out_valid/out_ready;
//        err (one-cycle underflow pulse). With PIPELINE_BISS_REV_STATS_EN defined also
//        tok_cnt (output transfers, wrapping) and err_cnt (err pulses, saturating).
module pipeline_biss_rev
    import pipeline_biss_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
`ifdef PIPELINE_BISS_REV_STATS_EN
    ,
    output logic [WIDTH-1:0] tok_cnt,
    output logic [WIDTH-1:0] err_cnt
`endif
);

    localparam logic [WIDTH-1:0] UF_MIN = WIDTH'(UNDERFLOW_MIN);

    logic             s1_vld, s2_vld;
    logic [WIDTH-1:0] s1_dat, s2_dat;
    logic             s2_rdy, s3_rdy;
    logic             tok_ok;
    logic             tok_uf;
    logic             err_q, err_d;

    // Zero is a bubble; 1..UF_MIN-1 would wrap, so both are swallowed at the input.
    assign tok_ok = (in_data >= UF_MIN);
    assign tok_uf = (in_data != '0) && !tok_ok;

    pipeline_biss_rev_stage #(.WIDTH(WIDTH), .OFFSET(OFF1)) u_stage1 (
        .clk      (clk),
        .rst      (rst),
        .up_vld_i (in_valid && tok_ok),
        .up_dat_i (in_data),
        .up_rdy_o (in_ready),
        .dn_vld_o (s1_vld),
        .dn_dat_o (s1_dat),
        .dn_rdy_i (s2_rdy)
    );

    pipeline_biss_rev_stage #(.WIDTH(WIDTH), .OFFSET(OFF2)) u_stage2 (
        .clk      (clk),
        .rst      (rst),
        .up_vld_i (s1_vld),
        .up_dat_i (s1_dat),
        .up_rdy_o (s2_rdy),
        .dn_vld_o (s2_vld),
        .dn_dat_o (s2_dat),
        .dn_rdy_i (s3_rdy)
    );

    pipeline_biss_rev_stage #(.WIDTH(WIDTH), .OFFSET(OFF3)) u_stage3 (
        .clk      (clk),
        .rst      (rst),
        .up_vld_i (s2_vld),
        .up_dat_i (s2_dat),
        .up_rdy_o (s3_rdy),
        .dn_vld_o (out_valid),
        .dn_dat_o (out_data),
        .dn_rdy_i (out_ready)
    );

    // Pulse in the cycle after an underflow token is accepted.
    assign err_d = in_valid && in_ready && tok_uf;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifdef PIPELINE_BISS_REV_STATS_EN
    logic [WIDTH-1:0] tok_cnt_q, tok_cnt_d;
    logic [WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        tok_cnt_d = tok_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_valid && out_ready) begin
            tok_cnt_d = tok_cnt_q + WIDTH'(1);
        end
        if (err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            tok_cnt_q <= tok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tok_cnt = tok_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipeline_biss_rev.sv
// Bench for pipeline_biss_rev: directed scenarios plus randomized traffic against a token-queue model.
module tb_pipeline_biss_rev;

    localparam int W = 16;
    localparam int DEC = 1110;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err;
`ifdef PIPELINE_BISS_REV_STATS_EN
    logic [W-1:0] tok_cnt;
    logic [W-1:0] err_cnt;
`endif

    pipeline_biss_rev #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
`ifdef PIPELINE_BISS_REV_STATS_EN
        ,
        .tok_cnt   (tok_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // Tokens in flight, in order; a token is visible at the output from 3 cycles after
    // acceptance, or as soon as its predecessor leaves, whichever is later.
    typedef struct {
        logic [W-1:0] val;
        int           t;
    } tok_t;

    tok_t         q[$];
    int           cyc = 0;
    logic         err_pend = 1'b0;
    logic         rst_prev = 1'b0;
    logic         exp_v;
    logic         exp_rdy;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    int           tok_m = 0;
    int           err_m = 0;
    tok_t         nt;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rst_prev) begin
                    chk("rst_out_valid", out_valid, 0);
                    chk("rst_out_data", out_data, 0);
                    chk("rst_err", err, 0);
`ifdef PIPELINE_BISS_REV_STATS_EN
                    chk("rst_tok_cnt", tok_cnt, 0);
                    chk("rst_err_cnt", err_cnt, 0);
`endif
                end
                q.delete();
                err_pend   = 1'b0;
                tok_m      = 0;
                err_m      = 0;
                prev_stall = 1'b0;
                rst_prev   = 1'b1;
            end else begin
                exp_v   = (q.size() > 0) && (cyc >= q[0].t + 3);
                exp_rdy = !((q.size() == 3) && !out_ready);
                chk("m_out_valid", out_valid, exp_v);
                if (exp_v) chk("m_out_data", out_data, q[0].val);
                chk("m_err", err, err_pend);
                chk("m_in_ready", in_ready, exp_rdy);
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, prev_data);
                end
`ifdef PIPELINE_BISS_REV_STATS_EN
                chk("m_tok_cnt", tok_cnt, tok_m & 32'hFFFF);
                chk("m_err_cnt", err_cnt, err_m);
`endif
                prev_stall = exp_v && !out_ready;
                prev_data  = out_data;
                if (exp_v && out_ready) begin
                    void'(q.pop_front());
                    tok_m++;
                end
                if (err_pend && err_m < 65535) err_m++;
                err_pend = in_valid && exp_rdy && (in_data != 0) && (in_data < DEC);
                if (in_valid && exp_rdy && in_data >= DEC) begin
                    nt.val = in_data - W'(DEC);
                    nt.t   = cyc;
                    q.push_back(nt);
                end
                rst_prev = 1'b0;
            end
            cyc++;
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int           sent;
    int           r;
    logic [W-1:0] recv[$];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset state, first cycle after rst falls.
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_err", err, 0);
        chk("reset_in_ready", in_ready, 1);
        next_cycle();

        // 1115 -> 5 exactly 3 cycles after acceptance.
        in_valid = 1'b1;
        in_data  = 16'd1115;
        @(negedge clk);
        chk("a_accept", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                chk("a_early_valid", out_valid, 0);
            end else begin
                chk("a_valid", out_valid, 1);
                chk("a_data", out_data, 5);
                chk("a_err", err, 0);
            end
            next_cycle();
        end

        // Back-to-back 1111..1114 -> 1,2,3,4 on consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4);
            in_data  = W'(1111 + i);
            @(negedge clk);
            if (i >= 3 && i <= 6) begin
                chk("b_valid", out_valid, 1);
                chk("b_data", out_data, i - 2);
            end
            next_cycle();
        end
        in_valid = 1'b0;

        // Six stalled cycles while offering five tokens, then drain.
        sent = 0;
        recv.delete();
        for (int c = 0; c < 20; c++) begin
            out_ready = (c >= 6);
            in_valid  = (sent < 5);
            in_data   = W'(1120 + sent);
            @(negedge clk);
            if (c == 5) begin
                chk("c_accepted", sent, 3);
                chk("c_in_ready_low", in_ready, 0);
            end
            if (c >= 3 && c < 6) begin
                chk("c_stall_valid", out_valid, 1);
                chk("c_stall_data", out_data, 10);
            end
            if (out_valid && out_ready) recv.push_back(out_data);
            if (in_valid && in_ready) sent++;
            next_cycle();
        end
        in_valid = 1'b0;
        chk("c_count", recv.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < recv.size()) chk("c_order", recv[i], 10 + i);
        end

        // 500 (underflow), 0 (bubble), 1110 (decodes to 0).
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 3);
            in_data  = (c == 0) ? 16'd500 : (c == 1) ? 16'd0 : 16'd1110;
            @(negedge clk);
            chk("d_err", err, (c == 1));
            chk("d_valid", out_valid, (c == 5));
            if (c == 5) chk("d_data", out_data, 0);
            next_cycle();
        end
        in_valid = 1'b0;

        // Reset with three tokens in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = W'(1200 + c);
            next_cycle();
        end
        rst      = 1'b1;
        in_data  = 16'd1300;
        next_cycle();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("e_valid", out_valid, 0);
            if (c == 0) begin
                chk("e_in_ready", in_ready, 1);
`ifdef PIPELINE_BISS_REV_STATS_EN
                chk("e_tok_cnt", tok_cnt, 0);
`endif
            end
            next_cycle();
        end

        // Randomized traffic, occasional resets; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 249) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            if (r < 10)      in_data = '0;
            else if (r < 25) in_data = W'($urandom_range(1, DEC - 1));
            else if (r < 30) in_data = W'(DEC);
            else if (r < 85) in_data = W'(DEC + $urandom_range(0, 3000));
            else             in_data = W'($urandom);
            next_cycle();
        end

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_biss_rev.md
PIPELINE_BISS_REV -- requirements
Module: pipeline_biss_rev

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of all data ports.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_data  input  WIDTH  encoded token; 0 = bubble.
REQ-005 SHALL have port: in_valid  input  1  in_data presented.
REQ-006 SHALL have port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port: out_data  output  WIDTH  decoded token.
REQ-008 SHALL have port: out_valid  output  1  out_data holds a decoded token.
REQ-009 SHALL have port: out_ready  input  1  sink accepts out_data this cycle.
REQ-010 SHALL have port: err  output  1  one-cycle underflow pulse.

Function
REQ-011 SHALL decode the +10/+100/+1000 encoding by subtracting 1000 in stage 1, 100 in stage 2 and 10 in stage 3, in that order.
REQ-012 SHALL hold one entry per stage: a valid bit and a WIDTH-bit data register.
REQ-013 SHALL make stage i ready when its valid bit is 0 or stage i+1 is ready; stage 3 ready = !out_valid || out_ready; in_ready = stage-1 ready (combinational chain).
REQ-014 SHALL transfer on in_valid && in_ready at input and on out_valid && out_ready at output; no other event moves data.
REQ-015 SHALL give a latency of 3 cycles from input transfer to out_valid with out_ready held high, and a throughput of one token per cycle.
REQ-016 SHALL accept and discard a token with in_data == 0: no stage loaded, no err.
REQ-017 SHALL accept and discard a token with 0 < in_data < 1110 (underflow), and SHALL assert err for exactly the cycle after acceptance.
REQ-018 SHALL pass in_data == 1110 as a valid token with out_data = 0; out_valid, not the data value, marks validity at the output.
REQ-019 SHALL use modulo-2^WIDTH arithmetic; no underflow is possible for in_data >= 1110.
REQ-020 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL preserve token order; no token SHALL be lost or duplicated under any out_ready pattern.
REQ-022 SHALL, when all three stages are full and out_ready is low, drive in_ready low.
REQ-023 SHALL, on simultaneous output transfer and input transfer with a full pipe, shift all stages and load stage 1 in the same cycle.

Reset
REQ-024 SHALL, while rst is high, clear all stage valid bits, set out_data to 0 and out_valid to 0, and clear err to 0.
REQ-025 SHALL discard all in-flight tokens on reset mid-stream; in_ready SHALL read 1 in the first cycle after rst falls.
REQ-026 SHALL ignore in_valid during cycles in which rst is high.

Configuration
REQ-027 SHALL, with PIPELINE_BISS_REV_STATS_EN defined, add the port tok_cnt  output  WIDTH, incremented on each output transfer, wrapping at 2^WIDTH and reset to 0.
REQ-028 SHALL, with PIPELINE_BISS_REV_STATS_EN defined, add the port err_cnt  output  WIDTH, incremented on each err pulse, saturating at all-ones and reset to 0.
REQ-029 SHALL, without PIPELINE_BISS_REV_STATS_EN, omit both ports and their logic; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL take OFF1 = 1000, OFF2 = 100, OFF3 = 10 and UNDERFLOW_MIN = 1110 from the shared package pipeline_biss_pkg, which the encoder stages also use.
REQ-031 SHALL build each stage as one instance of sub-module pipeline_biss_rev_stage, with the subtracted offset as a parameter and valid/ready ports.

Verification
REQ-032 SHALL cover: in_data 1115 (one transfer, out_ready = 1) -> out_valid with out_data 5 in cycle 3 after acceptance, err = 0.
REQ-033 SHALL cover: 1111, 1112, 1113, 1114 back-to-back -> out_data 1, 2, 3, 4 on four consecutive cycles.
REQ-034 SHALL cover: out_ready = 0 for 6 cycles while 5 tokens are offered -> in_ready low after 3 accepted, out_data stable; then out_ready = 1 -> all 5 out in order.
REQ-035 SHALL cover: in_data 500, then 0, then 1110 -> one err pulse after 500, nothing for 0, out_data 0 with out_valid = 1 for 1110.
REQ-036 SHALL cover: rst pulsed with 3 tokens in flight -> out_valid = 0 next cycle, no stale output afterwards; with PIPELINE_BISS_REV_STATS_EN, tok_cnt = 0.
